// File: rtl/store_narrower_pkg.sv
// rtl/store_narrower_pkg.sv - size encodings, byte-enable constants and the store buffer entry type
package store_pkg;

  localparam int STORE_ADDR_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } store_size_e;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_LANE0   = 4'b0001;
  localparam logic [3:0] BE_LANE1   = 4'b0010;
  localparam logic [3:0] BE_LANE2   = 4'b0100;
  localparam logic [3:0] BE_LANE3   = 4'b1000;
  localparam logic [3:0] BE_LO_HALF = BE_LANE1 | BE_LANE0;
  localparam logic [3:0] BE_HI_HALF = BE_LANE3 | BE_LANE2;
  localparam logic [3:0] BE_ALL     = 4'b1111;

  typedef struct packed {
    logic [STORE_ADDR_W-1:0] addr;
    logic [31:0]             wdata;
    logic [3:0]              be;
  } store_entry_t;

endpackage

// File: rtl/store_narrower_if.sv
// rtl/store_narrower_if.sv - store request side and data-memory write port of the store narrower
interface store_narrower_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_data;
  logic [1:0]        req_size;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              misalign;
  logic [ADDR_W-1:0] misalign_addr;

  modport master (
    output req_valid, req_addr, req_data, req_size, mem_ready,
    input  req_ready, mem_valid, mem_addr, mem_wdata, mem_be, misalign, misalign_addr
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_size, mem_ready,
    output req_ready, mem_valid, mem_addr, mem_wdata, mem_be, misalign, misalign_addr
  );
endinterface

// File: rtl/store_narrower_lane_gen.sv
// rtl/store_narrower_lane_gen.sv - lane replication, byte enables and alignment check for SB/SH/SW
// STORE_BIGENDIAN_EN selects big-endian byte-lane numbering; default is little-endian.
module store_lane_gen
  import store_pkg::*;
(
  input  logic [1:0]  addr,
  input  store_size_e size,
  input  logic [31:0] data,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic        misaligned
);

  always_comb begin
    wdata      = data;
    be         = BE_ALL;
    misaligned = 1'b0;
    unique case (size)
      SZ_BYTE: begin
        wdata = {4{data[7:0]}};
`ifdef STORE_BIGENDIAN_EN
        be    = BE_LANE3 >> addr;
`else
        be    = BE_LANE0 << addr;
`endif
      end
      SZ_HALF: begin
        wdata      = {2{data[15:0]}};
`ifdef STORE_BIGENDIAN_EN
        be         = addr[1] ? BE_LO_HALF : BE_HI_HALF;
`else
        be         = addr[1] ? BE_HI_HALF : BE_LO_HALF;
`endif
        misaligned = addr[0];
      end
      SZ_WORD: begin
        misaligned = |addr;
      end
      SZ_ILL: begin
        be         = BE_NONE;
        misaligned = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/store_narrower.sv
// rtl/store_narrower.sv - narrows store data onto memory byte lanes and buffers stores in a FIFO
// Lane numbering follows STORE_BIGENDIAN_EN inside store_lane_gen.
module store_narrower
  import store_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32
) (
  input logic             clk,
  input logic             rst_n,
  store_narrower_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  store_entry_t  fifo_q [DEPTH];
  store_entry_t  new_entry;
  store_entry_t  head;

  logic [31:0] lane_wdata;
  logic [3:0]  lane_be;
  logic        lane_mis;
  logic        full;
  logic        accept;
  logic        push;
  logic        pop;

  store_lane_gen u_lane_gen (
    .addr       (bus.req_addr[1:0]),
    .size       (store_size_e'(bus.req_size)),
    .data       (bus.req_data),
    .wdata      (lane_wdata),
    .be         (lane_be),
    .misaligned (lane_mis)
  );

  // req_ready depends only on registered count, never on mem_ready
  assign full          = (count == CW'(DEPTH));
  assign bus.req_ready = !full;
  assign accept        = bus.req_valid && !full;
  assign push          = accept && !lane_mis;
  assign bus.mem_valid = (count != '0);
  assign pop           = bus.mem_valid && bus.mem_ready;

  assign new_entry.addr  = STORE_ADDR_W'({bus.req_addr[ADDR_W-1:2], 2'b00});
  assign new_entry.wdata = lane_wdata;
  assign new_entry.be    = lane_be;

  assign head          = fifo_q[rd_ptr];
  assign bus.mem_addr  = ADDR_W'(head.addr);
  assign bus.mem_wdata = head.wdata;
  assign bus.mem_be    = head.be;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_q[wr_ptr] <= new_entry;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Rejected requests are consumed without touching the buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.misalign      <= 1'b0;
      bus.misalign_addr <= '0;
    end else begin
      bus.misalign <= accept && lane_mis;
      if (accept && lane_mis) begin
        bus.misalign_addr <= bus.req_addr;
      end
    end
  end

endmodule

// File: doc/store_narrower.md
Name: store_narrower

Overview:
- Write-side counterpart of the load/immediate extension path: narrows 32-bit register store data onto the byte lanes of the 32-bit data-memory write port.
- Replicates data across lanes, generates byte enables and checks alignment for SB/SH/SW.
- Buffers accepted stores in a small FIFO and issues them to data memory over a valid/ready handshake.
- Sits between the MEM-stage store issue and the data-memory write port.

Parameters:
DEPTH, 2, store buffer entries (power of two, >=2)
ADDR_W, 32, byte address width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  store request present
req_ready  out  1  buffer can accept (= !full)
req_addr  in  ADDR_W  byte address
req_data  in  32  register data; low bits significant for byte/half
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
mem_valid  out  1  head entry presented to memory
mem_ready  in  1  memory accepts head
mem_addr  out  ADDR_W  word-aligned address (addr[1:0] forced 00)
mem_wdata  out  32  lane-replicated data
mem_be  out  4  byte enables, bit i = byte lane i
misalign  out  1  one-cycle pulse: rejected request
misalign_addr  out  ADDR_W  address of the last rejected request

Behaviour:
- Accept on req_valid && req_ready at a rising edge. No combinational path from mem_ready to req_ready. Full buffer deasserts req_ready even if a pop occurs in the same cycle.
- Alignment: half requires addr[0]==0; word requires addr[1:0]==00; size 11 is always illegal.
- A misaligned or illegal request is consumed but not queued. misalign pulses high for exactly the cycle after acceptance, and misalign_addr latches req_addr.
- Back-to-back misaligned requests give consecutive pulses; misalign_addr holds the latest address.
- Lane mapping (little-endian default):
  - byte: wdata={4{data[7:0]}}, be=4'b0001<<addr[1:0]
  - half: wdata={2{data[15:0]}}, be = addr[1] ? 4'b1100 : 4'b0011
  - word: wdata=data, be=4'b1111
- Lane data is computed at acceptance and stored in the entry; the entry holds {word addr, wdata, be}.
- Latency: a request accepted at edge N with an empty buffer gives mem_valid=1 in the following cycle.
- mem_valid = !empty. The head entry is popped on mem_valid && mem_ready.
- mem_addr, mem_wdata and mem_be stay stable while mem_valid && !mem_ready.
- Order is strict FIFO. Push and pop in the same cycle when not full leave the count unchanged.
- Pointers wrap modulo DEPTH; count is 0..DEPTH.
- Reset (asynchronous, any time, including mid-handshake):
  - count, pointers and storage clear to 0; queued stores are discarded.
  - mem_valid=0, mem_addr/mem_wdata/mem_be=0.
  - misalign=0, misalign_addr=0, req_ready=1 after reset release.
- An illegal request while full is not accepted (req_ready=0), so no misalign pulse is generated.

Optional Feature:
- STORE_BIGENDIAN_EN defined: big-endian lane numbering.
  - byte: be=4'b1000>>addr[1:0]
  - half: be = addr[1] ? 4'b0011 : 4'b1100
  - Replicated wdata is unchanged.
- Undefined: little-endian mapping as above.
- Alignment checks and handshakes are identical in both modes.

Decomposition:
- Package store_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILL
  - store_entry_t struct {addr, wdata, be}
  - be constants per lane
- One combinational sub-module, store_lane_gen: inputs addr[1:0], size, data; outputs wdata, be, misaligned. It holds the endian option.
- The FIFO and handshake logic stay in store_narrower.

Test Plan:
- SB addr=0x1003 data=0x000000AB, mem_ready=1 -> next cycle mem_valid=1, mem_addr=0x1000, wdata=0xABABABAB, be=1000 (BIGENDIAN: 0001).
- SH addr=0x2002 data=0x1234 -> wdata=0x12341234, be=1100; SW addr=0x3000 data=0xDEADBEEF -> be=1111, wdata=0xDEADBEEF.
- SH addr=0x2001, then SW addr=0x3002 -> misalign pulses in two consecutive cycles; misalign_addr=0x3002; mem_valid stays 0.
- mem_ready=0, push 3 words with DEPTH=2 -> req_ready drops after 2. Raise mem_ready -> issue order preserved and outputs stable while stalled.
- Full buffer with simultaneous pop -> req_ready stays 0 that cycle, count drops to 1 after the edge.
- Assert rst_n=0 with 2 queued entries and mem_valid high -> mem_valid, misalign and be go to 0 immediately (asynchronously); after release req_ready=1 and nothing reissues.
